fwd_hazard_ctrl: RTL

Parametrised forwarding and hazard controller for the 5-stage pipeline. It generates per-operand forwarding selects for the EX stage, covering ALU operand 1, ALU operand 2, store value and any further operands. It also detects load-use and no-forwarding hazards against ID-stage sources and drives a multi-cycle stall through a small FSM. Saturating event counters support performance debug. It sits beside the ID/EX and EX/MEM pipeline registers; its outputs feed the EX operand muxes and the IF/ID freeze / ID/EX flush logic.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 19 +
 rtl/fwd_hazard_ctrl_sel_lane.sv | 27 ++
 rtl/fwd_hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared widths, forwarding select encodings and stall FSM states for the
// EX-stage forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

   localparam int REG_LENGTH        = 4;
   localparam int FORWARDING_LENGTH = 2;

   typedef enum logic [FORWARDING_LENGTH-1:0] {
      FWD_SEL_RF  = 2'd0,
      FWD_SEL_MEM = 2'd1,
      FWD_SEL_WB  = 2'd2
   } fwd_sel_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } hz_state_e;

endpackage

// File: rtl/fwd_hazard_ctrl_sel_lane.sv
// Single-operand forwarding comparator: picks MEM over WB over register file
// for one EX-stage source.
module fwd_sel_lane
   import fwd_hazard_ctrl_pkg::*;
(
   input  logic [REG_LENGTH-1:0]        src_i,
   input  logic                         src_vld_i,
   input  logic                         fwd_en_i,
   input  logic [REG_LENGTH-1:0]        dst_mem_i,
   input  logic                         wb_en_mem_i,
   input  logic [REG_LENGTH-1:0]        dst_wb_i,
   input  logic                         wb_en_wb_i,
   output logic [FORWARDING_LENGTH-1:0] sel_o
);

   always_comb begin
      sel_o = FWD_SEL_RF;
      if (fwd_en_i && src_vld_i) begin
         if (wb_en_mem_i && (src_i == dst_mem_i)) begin
            sel_o = FWD_SEL_MEM;
         end else if (wb_en_wb_i && (src_i == dst_wb_i)) begin
            sel_o = FWD_SEL_WB;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select generation, load-use / no-forward hazard detection with a
// multi-cycle stall FSM, and saturating performance counters.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int NUM_SRC  = 3,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 fwd_en,
   input  logic                                 pipe_freeze,
   input  logic                                 cnt_clr,
   input  logic [NUM_SRC*REG_LENGTH-1:0]        src_id,
   input  logic [NUM_SRC-1:0]                   src_id_vld,
   input  logic [NUM_SRC*REG_LENGTH-1:0]        src_ex,
   input  logic [NUM_SRC-1:0]                   src_ex_vld,
   input  logic [REG_LENGTH-1:0]                dst_ex,
   input  logic                                 wb_en_ex,
   input  logic                                 mem_r_en_ex,
   input  logic [REG_LENGTH-1:0]                dst_mem,
   input  logic                                 wb_en_mem,
   input  logic [REG_LENGTH-1:0]                dst_wb,
   input  logic                                 wb_en_wb,
   output logic [NUM_SRC*FORWARDING_LENGTH-1:0] fwd_sel,
   output logic                                 hazard_stall,
   output logic [CNT_W-1:0]                     fwd_cnt,
   output logic [CNT_W-1:0]                     stall_cnt,
   output hz_state_e                            dbg_state,
   output logic [2:0]                           dbg_rem
);

   localparam logic       MULTI_STALL = (LOAD_LAT > 1);
   localparam logic [2:0] REM_INIT    = 3'(LOAD_LAT - 1);

   hz_state_e        state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             load_use;
   logic             no_fwd_hz;
   logic             comb_hazard;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
      fwd_sel_lane u_lane (
         .src_i      (src_ex[k*REG_LENGTH +: REG_LENGTH]),
         .src_vld_i  (src_ex_vld[k]),
         .fwd_en_i   (fwd_en),
         .dst_mem_i  (dst_mem),
         .wb_en_mem_i(wb_en_mem),
         .dst_wb_i   (dst_wb),
         .wb_en_wb_i (wb_en_wb),
         .sel_o      (fwd_sel[k*FORWARDING_LENGTH +: FORWARDING_LENGTH])
      );
   end

   // Load-use only matters when forwarding; otherwise any in-flight producer stalls.
   always_comb begin
      load_use  = 1'b0;
      no_fwd_hz = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_id_vld[k]) begin
            if (fwd_en && wb_en_ex && mem_r_en_ex &&
                (src_id[k*REG_LENGTH +: REG_LENGTH] == dst_ex)) begin
               load_use = 1'b1;
            end
            if (!fwd_en &&
                ((wb_en_ex  && (src_id[k*REG_LENGTH +: REG_LENGTH] == dst_ex)) ||
                 (wb_en_mem && (src_id[k*REG_LENGTH +: REG_LENGTH] == dst_mem)))) begin
               no_fwd_hz = 1'b1;
            end
         end
      end
      comb_hazard = load_use | no_fwd_hz;
   end

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      hazard_stall = comb_hazard;
      case (state_q)
         ST_IDLE: begin
            if (MULTI_STALL && load_use && !pipe_freeze) begin
               state_d = ST_STALL;
               rem_d   = REM_INIT;
            end
         end
         ST_STALL: begin
            hazard_stall = 1'b1;
            if (!pipe_freeze) begin
               if (rem_q == 3'd1) begin
                  state_d = ST_IDLE;
                  rem_d   = 3'd0;
               end else begin
                  rem_d = rem_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            rem_d   = 3'd0;
         end
      endcase
   end

   // Clear wins over increment; increments saturate at all-ones.
   always_comb begin
      fwd_cnt_d   = fwd_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (cnt_clr) begin
         fwd_cnt_d   = '0;
         stall_cnt_d = '0;
      end else if (!pipe_freeze) begin
         if ((|fwd_sel) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 1'b1;
         end
         if (hazard_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rem_q       <= 3'd0;
         fwd_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         fwd_cnt_q   <= fwd_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fwd_cnt   = fwd_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign dbg_state = state_q;
   assign dbg_rem   = rem_q;

endmodule
